multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 80 ++++++++
 rtl/multicycle_controller_op_decoder.sv | 97 +++++++++
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I control unit:
//   - FSM state encoding (also exported on the debug 'state' port)
//   - instruction class used by the FSM to choose its path
//   - alu_op encoding and datapath mux select codes
//   - major opcode constants
//   - alu_from_f3(): funct3/alt-bit to ALU operation mapping
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4
    } iclass_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic       PC_SRC_PLUS4 = 1'b0;
    localparam logic       PC_SRC_ALU   = 1'b1;

    localparam logic [1:0] SRC_A_RS1    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC  = 2'd1;
    localparam logic [1:0] SRC_A_ZERO   = 2'd2;

    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;

    localparam logic [1:0] WB_ALU       = 2'd0;
    localparam logic [1:0] WB_LOAD      = 2'd1;
    localparam logic [1:0] WB_LINK      = 2'd2;

    // i_alt selects SUB over ADD (funct3 000) and SRA over SRL (funct3 101)
    function automatic alu_op_t alu_from_f3(input logic [2:0] i_f3, input logic i_alt);
        alu_op_t w_op;
        case (i_f3)
            3'b000:  w_op = i_alt ? ALU_SUB : ALU_ADD;
            3'b001:  w_op = ALU_SLL;
            3'b010:  w_op = ALU_SLT;
            3'b011:  w_op = ALU_SLTU;
            3'b100:  w_op = ALU_XOR;
            3'b101:  w_op = i_alt ? ALU_SRA : ALU_SRL;
            3'b110:  w_op = ALU_OR;
            default: w_op = ALU_AND;
        endcase
        return w_op;
    endfunction

endpackage

// File: rtl/multicycle_controller_op_decoder.sv
// op_decoder: purely combinational instruction classification.
// Ports:
//   i_opcode/i_funct3/i_funct7 - instruction fields from the IR
//   o_legal                    - instruction is a supported RV32I encoding
//   o_iclass                   - path the FSM takes (ALU/LOAD/STORE/BRANCH/JUMP)
//   o_alu_op                   - ALU operation
//   o_alu_src_a/o_alu_src_b    - ALU operand selects
//   o_wb_sel                   - register write-back source
module op_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic       o_legal,
    output iclass_t    o_iclass,
    output logic [3:0] o_alu_op,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_wb_sel
);

    logic w_f7_zero;
    logic w_f7_alt;

    assign w_f7_zero = (i_funct7 == 7'b0000000);
    assign w_f7_alt  = (i_funct7 == 7'b0100000);

    always_comb begin
        o_legal     = 1'b0;
        o_iclass    = CLS_ALU;
        o_alu_op    = ALU_ADD;
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_RS2;
        o_wb_sel    = WB_ALU;

        case (i_opcode)
            OPC_OP: begin
                o_legal  = w_f7_zero ||
                           (w_f7_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101));
                o_alu_op = alu_from_f3(i_funct3, i_funct7[5]);
            end
            OPC_OP_IMM: begin
                // funct7 is immediate data except for the shift-immediate forms
                case (i_funct3)
                    3'b001:  o_legal = w_f7_zero;
                    3'b101:  o_legal = w_f7_zero || w_f7_alt;
                    default: o_legal = 1'b1;
                endcase
                o_alu_op    = alu_from_f3(i_funct3, (i_funct3 == 3'b101) && i_funct7[5]);
                o_alu_src_b = SRC_B_IMM;
            end
            OPC_LOAD: begin
                o_legal     = !(i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111);
                o_iclass    = CLS_LOAD;
                o_alu_src_b = SRC_B_IMM;
                o_wb_sel    = WB_LOAD;
            end
            OPC_STORE: begin
                o_legal     = (i_funct3 <= 3'b010);
                o_iclass    = CLS_STORE;
                o_alu_src_b = SRC_B_IMM;
            end
            OPC_BRANCH: begin
                o_legal     = !(i_funct3 == 3'b010 || i_funct3 == 3'b011);
                o_iclass    = CLS_BRANCH;
                o_alu_src_a = SRC_A_OLDPC;
                o_alu_src_b = SRC_B_IMM;
            end
            OPC_LUI: begin
                o_legal     = 1'b1;
                o_alu_src_a = SRC_A_ZERO;
                o_alu_src_b = SRC_B_IMM;
            end
            OPC_AUIPC: begin
                o_legal     = 1'b1;
                o_alu_src_a = SRC_A_OLDPC;
                o_alu_src_b = SRC_B_IMM;
            end
            OPC_JAL: begin
                o_legal     = 1'b1;
                o_iclass    = CLS_JUMP;
                o_alu_src_a = SRC_A_OLDPC;
                o_alu_src_b = SRC_B_IMM;
                o_wb_sel    = WB_LINK;
            end
            OPC_JALR: begin
                o_legal     = (i_funct3 == 3'b000);
                o_iclass    = CLS_JUMP;
                o_alu_src_b = SRC_B_IMM;
                o_wb_sel    = WB_LINK;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB control FSM for a
// multicycle RV32I datapath, with a sticky illegal-instruction TRAP state.
// Ports:
//   clk, rst_n                 - clock (rising edge), async active-low reset
//   opcode/funct3/funct7       - IR fields
//   cmp_eq/cmp_lt/cmp_ltu      - rs1 vs rs2 comparator flags
//   imem_ready/dmem_ready      - memory completion strobes
//   imem_req/dmem_req/dmem_we  - memory requests, store enable
//   ir_write/pc_write/reg_write- datapath register enables
//   pc_src, alu_src_a/b, alu_op, wb_sel - datapath mux/ALU controls
//   trap                       - illegal instruction seen (held until reset)
//   instret                    - retired instruction count
//   state                      - current FSM state (debug)
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        cmp_eq,
    input  logic        cmp_lt,
    input  logic        cmp_ltu,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instret;

    logic        w_legal;
    iclass_t     w_iclass;
    logic [3:0]  w_dec_alu_op;
    logic [1:0]  w_dec_src_a;
    logic [1:0]  w_dec_src_b;
    logic [1:0]  w_dec_wb_sel;

    logic        w_taken;
    logic        w_retire;
    logic        w_imem_req;
    logic        w_dmem_req;
    logic        w_dmem_we;
    logic        w_ir_write;
    logic        w_pc_write;
    logic        w_reg_write;

    op_decoder u_op_decoder (
        .i_opcode    (opcode),
        .i_funct3    (funct3),
        .i_funct7    (funct7),
        .o_legal     (w_legal),
        .o_iclass    (w_iclass),
        .o_alu_op    (w_dec_alu_op),
        .o_alu_src_a (w_dec_src_a),
        .o_alu_src_b (w_dec_src_b),
        .o_wb_sel    (w_dec_wb_sel)
    );

    always_comb begin
        case (funct3)
            3'b000:  w_taken =  cmp_eq;
            3'b001:  w_taken = !cmp_eq;
            3'b100:  w_taken =  cmp_lt;
            3'b101:  w_taken = !cmp_lt;
            3'b110:  w_taken =  cmp_ltu;
            3'b111:  w_taken = !cmp_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_reg_write = 1'b0;
        pc_src      = PC_SRC_PLUS4;
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        alu_op      = ALU_ADD;
        wb_sel      = WB_ALU;

        // Operand selects stay valid from EXEC through WB so the ALU result
        // is still the jump target when WB writes the PC.
        if (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) begin
            alu_src_a = w_dec_src_a;
            alu_src_b = w_dec_src_b;
            alu_op    = w_dec_alu_op;
        end

        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next = w_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                case (w_iclass)
                    CLS_LOAD, CLS_STORE: w_next = ST_MEM;
                    CLS_BRANCH: begin
                        if (w_taken) begin
                            w_pc_write = 1'b1;
                            pc_src     = PC_SRC_ALU;
                        end
                        w_next   = ST_FETCH;
                        w_retire = 1'b1;
                    end
                    default: w_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (w_iclass == CLS_STORE);
                if (dmem_ready) begin
                    if (w_iclass == CLS_STORE) begin
                        w_next   = ST_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_reg_write = 1'b1;
                wb_sel      = w_dec_wb_sel;
                if (w_iclass == CLS_JUMP) begin
                    w_pc_write = 1'b1;
                    pc_src     = PC_SRC_ALU;
                end
                w_next   = ST_FETCH;
                w_retire = 1'b1;
            end
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_FETCH;
        endcase
    end

    // rst_n gating makes requests/enables drop immediately on reset assertion,
    // aborting any in-flight memory access without waiting for a clock edge.
    assign imem_req  = w_imem_req  & rst_n;
    assign dmem_req  = w_dmem_req  & rst_n;
    assign dmem_we   = w_dmem_we   & rst_n;
    assign ir_write  = w_ir_write  & rst_n;
    assign pc_write  = w_pc_write  & rst_n;
    assign reg_write = w_reg_write & rst_n;

    assign trap    = (r_state == ST_TRAP);
    assign instret = r_instret;
    assign state   = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        cmp_eq, cmp_lt, cmp_ltu;
    logic        imem_ready, dmem_ready;
    logic        imem_req, dmem_req, dmem_we;
    logic        ir_write, pc_write, reg_write;
    logic        pc_src;
    logic [1:0]  alu_src_a, alu_src_b;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [31:0] instret;
    logic [2:0]  state;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .cmp_eq     (cmp_eq),
        .cmp_lt     (cmp_lt),
        .cmp_ltu    (cmp_ltu),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .trap       (trap),
        .instret    (instret),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Expected state codes: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       eq, lt, ltu;
        logic       legal;
        logic [3:0] alu;
        logic [1:0] sa, sb;
        logic       pcw;
        logic [2:0] nxt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int opc, input int f3, input int f7,
                                input int eq, input int lt, input int ltu,
                                input int legal, input int alu, input int sa,
                                input int sb, input int pcw, input int nxt);
        vec_t v;
        v.opc = opc[6:0]; v.f3 = f3[2:0]; v.f7 = f7[6:0];
        v.eq = eq[0]; v.lt = lt[0]; v.ltu = ltu[0];
        v.legal = legal[0]; v.alu = alu[3:0]; v.sa = sa[1:0]; v.sb = sb[1:0];
        v.pcw = pcw[0]; v.nxt = nxt[2:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        cmp_eq = 1'b0; cmp_lt = 1'b0; cmp_ltu = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    // From FETCH with zero-wait imem: returns 2 ns after the edge entering EXEC/TRAP
    task automatic fetch_to_exec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        opcode = opc; funct3 = f3; funct7 = f7;
        imem_ready = 1'b1;
        #1;
        step();
        imem_ready = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //        opc   f3  f7   eq lt ltu lgl alu sa sb pcw nxt
        vecs.push_back(mk('h33, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 0, 4)); // ADD
        vecs.push_back(mk('h33, 0, 'h20, 0, 0, 0, 1, 1, 0, 0, 0, 4)); // SUB
        vecs.push_back(mk('h33, 5, 'h20, 0, 0, 0, 1, 7, 0, 0, 0, 4)); // SRA
        vecs.push_back(mk('h33, 3, 'h00, 0, 0, 0, 1, 4, 0, 0, 0, 4)); // SLTU
        vecs.push_back(mk('h33, 4, 'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // XOR alt: illegal
        vecs.push_back(mk('h33, 0, 'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // MUL: illegal
        vecs.push_back(mk('h13, 0, 'h7F, 0, 0, 0, 1, 0, 0, 1, 0, 4)); // ADDI neg imm
        vecs.push_back(mk('h13, 1, 'h00, 0, 0, 0, 1, 2, 0, 1, 0, 4)); // SLLI
        vecs.push_back(mk('h13, 1, 'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // SLLI alt: illegal
        vecs.push_back(mk('h13, 5, 'h20, 0, 0, 0, 1, 7, 0, 1, 0, 4)); // SRAI
        vecs.push_back(mk('h13, 5, 'h00, 0, 0, 0, 1, 6, 0, 1, 0, 4)); // SRLI
        vecs.push_back(mk('h13, 5, 'h21, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // SRxI bad f7
        vecs.push_back(mk('h13, 6, 'h55, 0, 0, 0, 1, 8, 0, 1, 0, 4)); // ORI
        vecs.push_back(mk('h03, 2, 'h00, 0, 0, 0, 1, 0, 0, 1, 0, 3)); // LW
        vecs.push_back(mk('h03, 3, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // LD: illegal
        vecs.push_back(mk('h23, 2, 'h00, 0, 0, 0, 1, 0, 0, 1, 0, 3)); // SW
        vecs.push_back(mk('h23, 3, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // SD: illegal
        vecs.push_back(mk('h63, 0, 'h00, 1, 0, 0, 1, 0, 1, 1, 1, 0)); // BEQ taken
        vecs.push_back(mk('h63, 4, 'h00, 0, 0, 0, 1, 0, 1, 1, 0, 0)); // BLT not taken
        vecs.push_back(mk('h63, 5, 'h00, 0, 0, 0, 1, 0, 1, 1, 1, 0)); // BGE taken
        vecs.push_back(mk('h63, 7, 'h00, 0, 0, 0, 1, 0, 1, 1, 1, 0)); // BGEU taken
        vecs.push_back(mk('h63, 6, 'h00, 0, 1, 1, 1, 0, 1, 1, 1, 0)); // BLTU taken
        vecs.push_back(mk('h63, 7, 'h00, 0, 0, 1, 1, 0, 1, 1, 0, 0)); // BGEU not taken
        vecs.push_back(mk('h63, 2, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // branch f3=2: illegal
        vecs.push_back(mk('h37, 0, 'h00, 0, 0, 0, 1, 0, 2, 1, 0, 4)); // LUI
        vecs.push_back(mk('h17, 0, 'h00, 0, 0, 0, 1, 0, 1, 1, 0, 4)); // AUIPC
        vecs.push_back(mk('h6F, 3, 'h11, 0, 0, 0, 1, 0, 1, 1, 0, 4)); // JAL
        vecs.push_back(mk('h67, 0, 'h00, 0, 0, 0, 1, 0, 0, 1, 0, 4)); // JALR
        vecs.push_back(mk('h67, 1, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // JALR f3=1: illegal
        vecs.push_back(mk('h0F, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // FENCE: illegal
        vecs.push_back(mk('h00, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // zero word

        opcode = '0; funct3 = '0; funct7 = '0;
        cmp_eq = 1'b0; cmp_lt = 1'b0; cmp_ltu = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;

        // Reset state and first post-reset cycle
        rst_n = 1'b0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_instret", instret, 0);
        chk("rst_trap", trap, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("post_rst_imem_req", imem_req, 1);

        // ADD x3,x1,x2 with two imem wait cycles
        opcode = 7'h33; funct3 = 3'd0; funct7 = 7'h00;
        chk("add_f1_ir_write", ir_write, 0);
        step(); #1;
        chk("add_f2_state", state, 0);
        chk("add_f2_imem_req", imem_req, 1);
        step();
        imem_ready = 1'b1; #1;
        chk("add_f3_ir_write", ir_write, 1);
        chk("add_f3_pc_write", pc_write, 1);
        chk("add_f3_pc_src", pc_src, 0);
        step();
        imem_ready = 1'b0; #1;
        chk("add_decode_state", state, 1);
        step(); #1;
        chk("add_exec_state", state, 2);
        chk("add_exec_alu_op", alu_op, 0);
        step(); #1;
        chk("add_wb_state", state, 4);
        chk("add_wb_reg_write", reg_write, 1);
        chk("add_wb_sel", wb_sel, 0);
        step(); #1;
        chk("add_fetch_state", state, 0);
        chk("add_instret", instret, 1);
        chk("add_reg_write_off", reg_write, 0);

        // Table-driven decode/exec vectors
        foreach (vecs[i]) begin
            reset_dut();
            opcode = vecs[i].opc; funct3 = vecs[i].f3; funct7 = vecs[i].f7;
            cmp_eq = vecs[i].eq; cmp_lt = vecs[i].lt; cmp_ltu = vecs[i].ltu;
            imem_ready = 1'b1; #1;
            chk($sformatf("v%0d_fetch_ir_write", i), ir_write, 1);
            step();
            imem_ready = 1'b0; #1;
            chk($sformatf("v%0d_decode_state", i), state, 1);
            chk($sformatf("v%0d_decode_enables", i),
                {ir_write, pc_write, reg_write, imem_req, dmem_req}, 0);
            step(); #1;
            if (vecs[i].legal) begin
                chk($sformatf("v%0d_exec_state", i), state, 2);
                chk($sformatf("v%0d_alu_op", i), alu_op, vecs[i].alu);
                chk($sformatf("v%0d_src_a", i), alu_src_a, vecs[i].sa);
                chk($sformatf("v%0d_src_b", i), alu_src_b, vecs[i].sb);
                chk($sformatf("v%0d_exec_pc_write", i), pc_write, vecs[i].pcw);
                if (vecs[i].pcw) chk($sformatf("v%0d_exec_pc_src", i), pc_src, 1);
                step(); #1;
                chk($sformatf("v%0d_next_state", i), state, vecs[i].nxt);
            end else begin
                chk($sformatf("v%0d_trap_state", i), state, 5);
                chk($sformatf("v%0d_trap_flag", i), trap, 1);
            end
        end

        // SW with one dmem wait cycle
        reset_dut();
        fetch_to_exec(7'h23, 3'd2, 7'h00);
        #1;
        chk("sw_exec_state", state, 2);
        step(); #1;
        chk("sw_mem1_state", state, 3);
        chk("sw_mem1_dmem_req", dmem_req, 1);
        chk("sw_mem1_dmem_we", dmem_we, 1);
        chk("sw_mem1_reg_write", reg_write, 0);
        step();
        dmem_ready = 1'b1; #1;
        chk("sw_mem2_dmem_req", dmem_req, 1);
        chk("sw_mem2_dmem_we", dmem_we, 1);
        step();
        dmem_ready = 1'b0; #1;
        chk("sw_done_state", state, 0);
        chk("sw_done_dmem_req", dmem_req, 0);
        chk("sw_instret", instret, 1);

        // BNE taken then not taken, back to back
        reset_dut();
        cmp_eq = 1'b0;
        fetch_to_exec(7'h63, 3'd1, 7'h00);
        #1;
        chk("bne_t_pc_write", pc_write, 1);
        chk("bne_t_pc_src", pc_src, 1);
        step(); #1;
        chk("bne_t_state", state, 0);
        chk("bne_t_instret", instret, 1);
        cmp_eq = 1'b1;
        fetch_to_exec(7'h63, 3'd1, 7'h00);
        #1;
        chk("bne_nt_pc_write", pc_write, 0);
        step(); #1;
        chk("bne_nt_state", state, 0);
        chk("bne_nt_instret", instret, 2);

        // Illegal opcode: TRAP absorbs even with imem_ready asserted
        reset_dut();
        fetch_to_exec(7'h0F, 3'd0, 7'h00);
        imem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("trap_c%0d_imem_req", k), imem_req, 0);
            chk($sformatf("trap_c%0d_trap", k), trap, 1);
            step();
        end
        imem_ready = 1'b0;
        #1;
        chk("trap_state_held", state, 5);

        // Reset during LW MEM phase aborts access
        reset_dut();
        fetch_to_exec(7'h33, 3'd0, 7'h00);
        step();
        step(); #1;
        chk("lwrst_pre_instret", instret, 1);
        fetch_to_exec(7'h03, 3'd2, 7'h00);
        step(); #1;
        chk("lwrst_mem_dmem_req", dmem_req, 1);
        chk("lwrst_mem_we", dmem_we, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lwrst_dmem_req_drop", dmem_req, 0);
        chk("lwrst_state", state, 0);
        chk("lwrst_instret", instret, 0);
        chk("lwrst_imem_req_low", imem_req, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("lwrst_release_imem_req", imem_req, 1);
        chk("lwrst_release_instret", instret, 0);

        // JAL write-back and jump in the same cycle
        reset_dut();
        fetch_to_exec(7'h6F, 3'd0, 7'h00);
        #1;
        chk("jal_exec_pc_write", pc_write, 0);
        step(); #1;
        chk("jal_wb_state", state, 4);
        chk("jal_wb_reg_write", reg_write, 1);
        chk("jal_wb_sel", wb_sel, 2);
        chk("jal_wb_pc_write", pc_write, 1);
        chk("jal_wb_pc_src", pc_src, 1);
        step(); #1;
        chk("jal_instret", instret, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
